writeback_regfile: RTL and testbench
====================================

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 64, giving the width of the retired-instruction counter.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port ValidW  input  1  the W-stage slot holds a real instruction, not a bubble.
REQ-005 The block SHALL have port RegWriteW  input  1  the instruction writes rd.
REQ-006 The block SHALL have port ResultSrcW  input  2  result select: 00 ALU, 01 load, 10 PC+4, 11 zero.
REQ-007 The block SHALL have port Funct3W  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-008 The block SHALL have port ReadDataW  input  32  raw aligned data-memory word.
REQ-009 The block SHALL have port ALUResultW  input  32  ALU result; bits [1:0] are the load byte offset.
REQ-010 The block SHALL have port PCPlus4W  input  32  link address.
REQ-011 The block SHALL have port RdW  input  5  destination register.
REQ-012 The block SHALL have ports A1D and A2D  input  5 each  D-stage source register addresses.
REQ-013 The block SHALL have ports RD1D and RD2D  output  32 each  D-stage read data.
REQ-014 The block SHALL have port ResultW  output  32  selected writeback value.
REQ-015 The block SHALL have port InstRetW  output  CNT_WIDTH  count of retired instructions.

Function
REQ-016 The block SHALL extract load data combinationally: byte = ReadDataW[8*ALUResultW[1:0] +: 8]; half = ReadDataW[16*ALUResultW[1] +: 16], with ALUResultW[0] ignored.
REQ-017 The block SHALL form load data as: LB sign-extends the byte; LBU zero-extends the byte; LH sign-extends the half; LHU zero-extends the half; LW passes the full word; Funct3W 011/110/111 pass the full word.
REQ-018 The block SHALL drive ResultW combinationally according to ResultSrcW: 00 ALUResultW, 01 load data, 10 PCPlus4W, 11 32'h0.
REQ-019 The block SHALL define the write enable WE = ValidW & RegWriteW & (RdW != 0).
REQ-020 The block SHALL hold 31 writable 32-bit registers x1..x31 and SHALL write ResultW into x[RdW] on the rising edge of clk when WE=1.
REQ-021 The block SHALL never store x0; reads of address 0 SHALL always return 32'h0.
REQ-022 The block SHALL have two independent combinational read ports.
REQ-023 The block SHALL resolve each read port by priority: address 0 -> 0; else WE=1 and RdW equals the address -> ResultW (same-cycle write-through bypass); else the stored value.
REQ-024 Both read ports reading the same address SHALL return identical data.
REQ-025 The block SHALL increment InstRetW by 1 on each rising edge with ValidW=1, independent of RegWriteW, and SHALL wrap from all-ones to 0.
REQ-026 The block SHALL not write or count when ValidW=0; all other inputs are don't-care in that cycle.
REQ-027 The block SHALL have zero-cycle read latency and SHALL make write data visible in the register array one cycle after the write edge, and via bypass in the write cycle itself.

Reset
REQ-028 The block SHALL, while rst_n=0, asynchronously clear x1..x31 to 32'h0 and InstRetW to 0, independent of clk.
REQ-029 The block SHALL give rst_n priority over any write or count in the same cycle; a reset asserted mid-operation SHALL discard the pending write.
REQ-030 The block SHALL present RD1D, RD2D and ResultW purely combinationally during reset; RD1D and RD2D SHALL read 0 except through the bypass path.
REQ-031 The block SHALL resume normal operation on the first rising edge after rst_n deasserts.

Verification
REQ-032 The bench SHALL cover reset: pulse rst_n low between clock edges -> InstRetW=0 and all 32 registers read 0 immediately, without a clock edge.
REQ-033 The bench SHALL cover bypass: ValidW=1, RegWriteW=1, RdW=5, ResultSrcW=00, ALUResultW=32'hDEADBEEF, A1D=5 in the same cycle -> RD1D=32'hDEADBEEF before the edge, and x5 holds it after the edge.
REQ-034 The bench SHALL cover x0: write RdW=0 with value 32'h12345678, A1D=A2D=0 -> RD1D=RD2D=0 in the write cycle and afterwards; InstRetW still increments.
REQ-035 The bench SHALL cover loads: ReadDataW=32'h80FF7F01, ResultSrcW=01 -> offset 3 LB gives 32'hFFFFFF80, offset 3 LBU gives 32'h00000080, offset 2 LH gives 32'hFFFF80FF, offset 0 LHU gives 32'h00007F01, LW gives 32'h80FF7F01.
REQ-036 The bench SHALL cover bubbles and the counter: ValidW=0 with RegWriteW=1, RdW=7 -> x7 unchanged and InstRetW unchanged; preload InstRetW to all-ones then one valid cycle -> InstRetW=0.
REQ-037 The bench SHALL cover reset mid-write: rst_n falls in a cycle with WE=1, RdW=9 -> x9=0 after reset is released.

Source files
------------

// File: rtl/writeback_regfile_if.sv
// Writeback-stage bus of the register file: W-stage result inputs, D-stage read
// ports and the retired-instruction count.
interface writeback_regfile_if #(
  parameter int CNT_WIDTH = 64
);
  logic                 ValidW;
  logic                 RegWriteW;
  logic [1:0]           ResultSrcW;
  logic [2:0]           Funct3W;
  logic [31:0]          ReadDataW;
  logic [31:0]          ALUResultW;
  logic [31:0]          PCPlus4W;
  logic [4:0]           RdW;
  logic [4:0]           A1D;
  logic [4:0]           A2D;
  logic [31:0]          RD1D;
  logic [31:0]          RD2D;
  logic [31:0]          ResultW;
  logic [CNT_WIDTH-1:0] InstRetW;

  modport master (
    output ValidW, RegWriteW, ResultSrcW, Funct3W, ReadDataW, ALUResultW,
           PCPlus4W, RdW, A1D, A2D,
    input  RD1D, RD2D, ResultW, InstRetW
  );

  modport slave (
    input  ValidW, RegWriteW, ResultSrcW, Funct3W, ReadDataW, ALUResultW,
           PCPlus4W, RdW, A1D, A2D,
    output RD1D, RD2D, ResultW, InstRetW
  );
endinterface

// File: rtl/writeback_regfile.sv
// Writeback stage: load extraction, result select, 31-entry register file with
// write-through bypass on both read ports, and a retired-instruction counter.
module writeback_regfile #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  writeback_regfile_if.slave  wb
);

  logic [31:0] regs [1:31];
  logic [7:0]  lbyte;
  logic [15:0] lhalf;
  logic [31:0] ldata;
  logic        we;

  // ALUResultW[0] is ignored for halfword selection
  always_comb begin
    lbyte = wb.ReadDataW[{wb.ALUResultW[1:0], 3'b000} +: 8];
    lhalf = wb.ReadDataW[{wb.ALUResultW[1], 4'b0000} +: 16];
    ldata = wb.ReadDataW;
    unique case (wb.Funct3W)
      3'b000:  ldata = {{24{lbyte[7]}}, lbyte};
      3'b001:  ldata = {{16{lhalf[15]}}, lhalf};
      3'b100:  ldata = {24'h0, lbyte};
      3'b101:  ldata = {16'h0, lhalf};
      default: ldata = wb.ReadDataW;
    endcase
  end

  always_comb begin
    wb.ResultW = '0;
    unique case (wb.ResultSrcW)
      2'b00:   wb.ResultW = wb.ALUResultW;
      2'b01:   wb.ResultW = ldata;
      2'b10:   wb.ResultW = wb.PCPlus4W;
      default: wb.ResultW = '0;
    endcase
  end

  assign we = wb.ValidW & wb.RegWriteW & (wb.RdW != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < 32; i++) begin
        regs[5'(i)] <= '0;
      end
    end else if (we) begin
      regs[wb.RdW] <= wb.ResultW;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.InstRetW <= '0;
    end else if (wb.ValidW) begin
      wb.InstRetW <= wb.InstRetW + CNT_WIDTH'(1);
    end
  end

  // Priority: x0, then same-cycle bypass, then array
  always_comb begin
    wb.RD1D = '0;
    if (wb.A1D == 5'd0) begin
      wb.RD1D = '0;
    end else if (we && (wb.RdW == wb.A1D)) begin
      wb.RD1D = wb.ResultW;
    end else begin
      wb.RD1D = regs[wb.A1D];
    end
  end

  always_comb begin
    wb.RD2D = '0;
    if (wb.A2D == 5'd0) begin
      wb.RD2D = '0;
    end else if (we && (wb.RdW == wb.A2D)) begin
      wb.RD2D = wb.ResultW;
    end else begin
      wb.RD2D = regs[wb.A2D];
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed self-checking bench for writeback_regfile; counter narrowed to 8 bits
// so the wrap from all-ones can be reached by counting.
module tb_writeback_regfile;

  localparam int CW = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [CW-1:0] cnt;

  writeback_regfile_if #(.CNT_WIDTH(CW)) wb ();

  writeback_regfile #(.CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, tracking the expected count, then settle off-edge
  task automatic tick();
    if (wb.ValidW === 1'b1 && rst_n === 1'b1) cnt = cnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb.ValidW = 1'b0; wb.RegWriteW = 1'b0; wb.ResultSrcW = 2'b00;
    wb.Funct3W = 3'b010; wb.ReadDataW = '0; wb.ALUResultW = '0;
    wb.PCPlus4W = '0; wb.RdW = '0;
  endtask

  task automatic wr_alu(input logic [4:0] rd, input logic [31:0] val);
    wb.ValidW = 1'b1; wb.RegWriteW = 1'b1; wb.ResultSrcW = 2'b00;
    wb.RdW = rd; wb.ALUResultW = val;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t lv [10];

  initial begin
    checks = 0; failures = 0; cnt = '0;
    lv[0] = '{3'b000, 2'd3, 32'hFFFFFF80};
    lv[1] = '{3'b100, 2'd3, 32'h00000080};
    lv[2] = '{3'b001, 2'd2, 32'hFFFF80FF};
    lv[3] = '{3'b101, 2'd0, 32'h00007F01};
    lv[4] = '{3'b010, 2'd0, 32'h80FF7F01};
    lv[5] = '{3'b001, 2'd3, 32'hFFFF80FF};
    lv[6] = '{3'b000, 2'd0, 32'h00000001};
    lv[7] = '{3'b000, 2'd1, 32'h0000007F};
    lv[8] = '{3'b100, 2'd2, 32'h000000FF};
    lv[9] = '{3'b011, 2'd1, 32'h80FF7F01};

    idle();
    wb.A1D = '0; wb.A2D = '0;
    rst_n = 1'b0;
    #12;
    check("reset_cnt", 64'(wb.InstRetW), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // A few writes so reset has something to clear
    wr_alu(5'd3, 32'h00000111);
    tick();
    wr_alu(5'd4, 32'h00000222);
    tick();
    idle();
    wb.A1D = 5'd3; wb.A2D = 5'd4; #1;
    check("x3_stored", 64'(wb.RD1D), 64'(32'h111));
    check("x4_stored", 64'(wb.RD2D), 64'(32'h222));
    check("cnt_two", 64'(wb.InstRetW), 64'(cnt));

    // Asynchronous reset pulse between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_cnt", 64'(wb.InstRetW), 64'(0));
    for (int a = 0; a < 32; a++) begin
      wb.A1D = 5'(a); wb.A2D = 5'(31 - a);
      #0.1;
      check($sformatf("rst_rd1_x%0d", a), 64'(wb.RD1D), 64'(0));
      check($sformatf("rst_rd2_x%0d", 31 - a), 64'(wb.RD2D), 64'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    cnt = '0;
    @(posedge clk); #1;

    // Same-cycle bypass
    wr_alu(5'd5, 32'hDEADBEEF);
    wb.A1D = 5'd5; wb.A2D = 5'd5; #1;
    check("bypass_rd1", 64'(wb.RD1D), 64'(32'hDEADBEEF));
    check("bypass_rd2", 64'(wb.RD2D), 64'(32'hDEADBEEF));
    tick();
    idle();
    #1;
    check("x5_after", 64'(wb.RD1D), 64'(32'hDEADBEEF));
    check("cnt_bypass", 64'(wb.InstRetW), 64'(cnt));

    // x0 is never written, yet the instruction retires
    wr_alu(5'd0, 32'h12345678);
    wb.A1D = 5'd0; wb.A2D = 5'd0; #1;
    check("x0_rd1_wc", 64'(wb.RD1D), 64'(0));
    check("x0_rd2_wc", 64'(wb.RD2D), 64'(0));
    check("x0_result", 64'(wb.ResultW), 64'(32'h12345678));
    tick();
    idle(); #1;
    check("x0_rd1_after", 64'(wb.RD1D), 64'(0));
    check("x0_rd2_after", 64'(wb.RD2D), 64'(0));
    check("x0_cnt", 64'(wb.InstRetW), 64'(cnt));

    // Load extraction and result select
    wb.ResultSrcW = 2'b01; wb.ReadDataW = 32'h80FF7F01;
    foreach (lv[i]) begin
      wb.Funct3W = lv[i].f3;
      wb.ALUResultW = {30'h0, lv[i].off};
      #1;
      check($sformatf("load_f%0d_o%0d", lv[i].f3, lv[i].off), 64'(wb.ResultW), 64'(lv[i].exp));
    end
    wb.ResultSrcW = 2'b10; wb.PCPlus4W = 32'h00001004; #1;
    check("sel_pc4", 64'(wb.ResultW), 64'(32'h00001004));
    wb.ResultSrcW = 2'b11; #1;
    check("sel_zero", 64'(wb.ResultW), 64'(0));

    // Load result written to the array
    wb.ValidW = 1'b1; wb.RegWriteW = 1'b1; wb.ResultSrcW = 2'b01;
    wb.Funct3W = 3'b000; wb.ALUResultW = 32'h00000002; wb.RdW = 5'd6;
    tick();
    idle(); wb.A1D = 5'd6; #1;
    check("x6_lb", 64'(wb.RD1D), 64'(32'hFFFFFFFF));

    // Bubble must neither write nor count
    wr_alu(5'd7, 32'h00000077);
    tick();
    idle();
    wb.RegWriteW = 1'b1; wb.RdW = 5'd7; wb.ALUResultW = 32'h00000BAD;
    wb.A1D = 5'd7; #1;
    check("bubble_nobypass", 64'(wb.RD1D), 64'(32'h77));
    tick();
    check("bubble_x7", 64'(wb.RD1D), 64'(32'h77));
    check("bubble_cnt", 64'(wb.InstRetW), 64'(cnt));

    // Counter to all-ones, then wrap
    idle();
    wb.ValidW = 1'b1;
    for (int n = 0; n < 300 && cnt != '1; n++) tick();
    check("cnt_all_ones", 64'(wb.InstRetW), 64'({CW{1'b1}}));
    tick();
    check("cnt_wrap", 64'(wb.InstRetW), 64'(0));
    idle();

    // Reset lands on a cycle with a pending write to x9
    wr_alu(5'd9, 32'h00000099);
    tick();
    idle(); wb.A1D = 5'd9; #1;
    check("x9_pre", 64'(wb.RD1D), 64'(32'h99));
    wr_alu(5'd9, 32'h00000055);
    #2;
    rst_n = 1'b0;
    @(posedge clk); #1;
    idle();
    rst_n = 1'b1;
    cnt = '0;
    #1;
    check("x9_rst_write", 64'(wb.RD1D), 64'(0));
    check("cnt_rst_write", 64'(wb.InstRetW), 64'(0));

    // Normal operation resumes on the first edge after release
    wr_alu(5'd9, 32'h0000ABCD);
    tick();
    idle(); #1;
    check("x9_resume", 64'(wb.RD1D), 64'(32'h0000ABCD));
    check("cnt_resume", 64'(wb.InstRetW), 64'(cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
